// File: rtl/latch_wr_sched_if.sv
// Bundle of requester-side and latch-bank-side signals for latch_wr_sched.
// The requester side drives req/addr/wdata. The scheduler drives everything else.
interface latch_wr_sched_if #(
  parameter int NREQ = 4,
  parameter int NLAT = 4,
  parameter int DW   = 1
);
  localparam int AW = (NLAT > 1) ? $clog2(NLAT) : 1;
  localparam int GW = $clog2(NREQ);

  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    ack;
  logic               err;
  logic               busy;
  logic [GW-1:0]      gnt_id;
  logic [DW-1:0]      lat_d;
  logic [NLAT-1:0]    lat_en;

  modport master (output req, addr, wdata,
                  input  ack, err, busy, gnt_id, lat_d, lat_en);
  modport slave  (input  req, addr, wdata,
                  output ack, err, busy, gnt_id, lat_d, lat_en);
endinterface

// File: rtl/latch_wr_sched.sv
// Round-robin write scheduler for a transparent-latch bank.
// It runs a SETUP / OPEN / HOLD sequence, so D is stable around every enable pulse.
module latch_wr_sched #(
  parameter int NREQ     = 4,
  parameter int NLAT     = 4,
  parameter int DW       = 1,
  parameter int OPEN_CYC = 2
) (
  input logic              clk,
  input logic              rst,
  latch_wr_sched_if.slave  bus
);
  localparam int AW = (NLAT > 1) ? $clog2(NLAT) : 1;
  localparam int GW = $clog2(NREQ);
  localparam int CW = (OPEN_CYC > 1) ? $clog2(OPEN_CYC) : 1;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_OPEN, S_HOLD, S_ACK} state_t;

  state_t            r_state, w_state_next;
  logic [CW-1:0]     r_cnt, w_cnt_next;
  logic [GW-1:0]     r_ptr, w_ptr_next;
  logic [GW-1:0]     r_gnt, w_gnt_next;
  logic [AW-1:0]     r_addr, w_addr_next;
  logic              r_oor, w_oor_next;
  logic [NREQ-1:0]   r_ack, w_ack_next;
  logic              r_err, w_err_next;
  logic              r_busy, w_busy_next;
  logic [DW-1:0]     r_lat_d, w_lat_d_next;
  logic [NLAT-1:0]   r_lat_en, w_lat_en_next;

  logic [AW-1:0]     w_addr [NREQ];
  logic [DW-1:0]     w_wdata [NREQ];
  logic [NLAT-1:0]   w_en_onehot;
  logic [NREQ-1:0]   w_gnt_onehot;
  logic              w_found;
  logic [GW-1:0]     w_win;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    assign w_addr[gi]       = bus.addr[gi*AW +: AW];
    assign w_wdata[gi]      = bus.wdata[gi*DW +: DW];
    assign w_gnt_onehot[gi] = (r_gnt == GW'(gi));
  end

  for (genvar gi = 0; gi < NLAT; gi++) begin : g_lat
    assign w_en_onehot[gi] = !r_oor && (r_addr == AW'(gi));
  end

  // The first active requester at or after r_ptr wins. The search wraps modulo NREQ.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && bus.req[(int'(r_ptr) + k) % NREQ]) begin
        w_found = 1'b1;
        w_win   = GW'((int'(r_ptr) + k) % NREQ);
      end
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_ptr_next    = r_ptr;
    w_gnt_next    = r_gnt;
    w_addr_next   = r_addr;
    w_oor_next    = r_oor;
    w_lat_d_next  = r_lat_d;
    w_lat_en_next = '0;
    w_ack_next    = '0;
    w_err_next    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_next = S_SETUP;
          w_gnt_next   = w_win;
          w_ptr_next   = GW'((int'(w_win) + 1) % NREQ);
          w_addr_next  = w_addr[w_win];
          w_oor_next   = (int'(w_addr[w_win]) >= NLAT);
          w_lat_d_next = w_wdata[w_win];
        end
      end
      S_SETUP: begin
        w_state_next  = S_OPEN;
        w_cnt_next    = CW'(OPEN_CYC - 1);
        w_lat_en_next = w_en_onehot;
      end
      S_OPEN: begin
        if (r_cnt == '0) begin
          w_state_next = S_HOLD;
        end else begin
          w_cnt_next    = r_cnt - 1'b1;
          w_lat_en_next = w_en_onehot;
        end
      end
      S_HOLD: begin
        w_state_next = S_ACK;
        w_ack_next   = w_gnt_onehot;
        w_err_next   = r_oor;
      end
      S_ACK:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    w_busy_next = (w_state_next != S_IDLE);
  end

  // Outputs are registered from the next-state values, so each one lines up with its own state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_ptr    <= '0;
      r_gnt    <= '0;
      r_addr   <= '0;
      r_oor    <= 1'b0;
      r_ack    <= '0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
      r_lat_d  <= '0;
      r_lat_en <= '0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_ptr    <= w_ptr_next;
      r_gnt    <= w_gnt_next;
      r_addr   <= w_addr_next;
      r_oor    <= w_oor_next;
      r_ack    <= w_ack_next;
      r_err    <= w_err_next;
      r_busy   <= w_busy_next;
      r_lat_d  <= w_lat_d_next;
      r_lat_en <= w_lat_en_next;
    end
  end

  assign bus.ack    = r_ack;
  assign bus.err    = r_err;
  assign bus.busy   = r_busy;
  assign bus.gnt_id = r_gnt;
  assign bus.lat_d  = r_lat_d;
  assign bus.lat_en = r_lat_en;
endmodule

// File: tb/tb_latch_wr_sched.sv
// Directed bench for latch_wr_sched.
// It uses the default build, an NLAT=5 build (out-of-range addresses) and an OPEN_CYC=1 build.
module tb_latch_wr_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  latch_wr_sched_if #(.NREQ(4), .NLAT(4), .DW(1)) if_a ();
  latch_wr_sched_if #(.NREQ(4), .NLAT(5), .DW(1)) if_b ();
  latch_wr_sched_if #(.NREQ(4), .NLAT(4), .DW(1)) if_c ();

  latch_wr_sched #(.NREQ(4), .NLAT(4), .DW(1), .OPEN_CYC(2)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  latch_wr_sched #(.NREQ(4), .NLAT(5), .DW(1), .OPEN_CYC(2)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
  latch_wr_sched #(.NREQ(4), .NLAT(4), .DW(1), .OPEN_CYC(1)) dut_c (.clk(clk), .rst(rst), .bus(if_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    if_a.req = '0; if_a.addr = '0; if_a.wdata = '0;
    if_b.req = '0; if_b.addr = '0; if_b.wdata = '0;
    if_c.req = '0; if_c.addr = '0; if_c.wdata = '0;
    rst = 1'b1;
    tick(); tick();
    checks++; if (if_a.ack !== 4'b0000) begin errors++; $display("FAIL reset_ack got %b exp 0000", if_a.ack); end
    checks++; if (if_a.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", if_a.err); end
    checks++; if (if_a.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", if_a.busy); end
    checks++; if (if_a.gnt_id !== 2'd0) begin errors++; $display("FAIL reset_gnt got %0d exp 0", if_a.gnt_id); end
    checks++; if (if_a.lat_d !== 1'b0) begin errors++; $display("FAIL reset_lat_d got %b exp 0", if_a.lat_d); end
    checks++; if (if_a.lat_en !== 4'b0000) begin errors++; $display("FAIL reset_lat_en got %b exp 0000", if_a.lat_en); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    if_a.req = 4'b0001; if_a.addr = 8'h02; if_a.wdata = 4'b0001;
    tick();  // t+1
    if_a.req = 4'b0000;
    checks++; if (if_a.lat_d !== 1'b1) begin errors++; $display("FAIL t1_lat_d got %b exp 1", if_a.lat_d); end
    checks++; if (if_a.lat_en !== 4'b0000) begin errors++; $display("FAIL t1_setup_en got %b exp 0000", if_a.lat_en); end
    checks++; if (if_a.busy !== 1'b1) begin errors++; $display("FAIL t1_busy1 got %b exp 1", if_a.busy); end
    tick();  // t+2
    checks++; if (if_a.lat_en !== 4'b0100) begin errors++; $display("FAIL t1_open1 got %b exp 0100", if_a.lat_en); end
    tick();  // t+3
    checks++; if (if_a.lat_en !== 4'b0100) begin errors++; $display("FAIL t1_open2 got %b exp 0100", if_a.lat_en); end
    tick();  // t+4
    checks++; if (if_a.lat_en !== 4'b0000) begin errors++; $display("FAIL t1_hold got %b exp 0000", if_a.lat_en); end
    checks++; if (if_a.ack !== 4'b0000) begin errors++; $display("FAIL t1_early_ack got %b exp 0000", if_a.ack); end
    tick();  // t+5
    $display("write t1: ack=%b err=%b gnt=%0d lat_d=%b", if_a.ack, if_a.err, if_a.gnt_id, if_a.lat_d);
    checks++; if (if_a.ack !== 4'b0001) begin errors++; $display("FAIL t1_ack got %b exp 0001", if_a.ack); end
    checks++; if (if_a.err !== 1'b0) begin errors++; $display("FAIL t1_err got %b exp 0", if_a.err); end
    checks++; if (if_a.busy !== 1'b1) begin errors++; $display("FAIL t1_busy5 got %b exp 1", if_a.busy); end
    tick();  // t+6
    checks++; if (if_a.busy !== 1'b0) begin errors++; $display("FAIL t1_idle_busy got %b exp 0", if_a.busy); end
    checks++; if (if_a.ack !== 4'b0000) begin errors++; $display("FAIL t1_ack_pulse got %b exp 0000", if_a.ack); end
    checks++; if (if_a.lat_d !== 1'b1) begin errors++; $display("FAIL t1_lat_d_hold got %b exp 1", if_a.lat_d); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] wd;
    int cyc;
    int en_cyc;
    int exp_id;
    rst = 1'b1; tick(); rst = 1'b0;
    wd = 4'b1010;
    if_a.req = 4'b1111; if_a.addr = {2'd3, 2'd2, 2'd1, 2'd0}; if_a.wdata = wd;
    for (int w = 0; w < 8; w++) begin
      exp_id = w % 4;
      cyc = 0;
      en_cyc = 0;
      while (1) begin
        tick();
        cyc++;
        if (if_a.lat_en !== 4'b0000) begin
          en_cyc++;
          checks++;
          if (if_a.lat_en !== (4'b0001 << exp_id)) begin
            errors++; $display("FAIL t2_en w%0d got %b exp %b", w, if_a.lat_en, 4'b0001 << exp_id);
          end
        end
        if (if_a.ack !== 4'b0000 || cyc > 12) break;
      end
      if (w == 7) if_a.req = 4'b0000;
      $display("write t2.%0d: ack=%b gnt=%0d lat_d=%b cycles=%0d", w, if_a.ack, if_a.gnt_id, if_a.lat_d, cyc);
      checks++; if (cyc > 12) begin errors++; $display("FAIL t2_timeout w%0d got %0d cycles exp <=12", w, cyc); end
      checks++; if (if_a.gnt_id !== 2'(exp_id)) begin errors++; $display("FAIL t2_gnt w%0d got %0d exp %0d", w, if_a.gnt_id, exp_id); end
      checks++; if (if_a.ack !== (4'b0001 << exp_id)) begin errors++; $display("FAIL t2_ack w%0d got %b exp %b", w, if_a.ack, 4'b0001 << exp_id); end
      checks++; if (cyc !== ((w == 0) ? 5 : 6)) begin errors++; $display("FAIL t2_spacing w%0d got %0d exp %0d", w, cyc, (w == 0) ? 5 : 6); end
      checks++; if (en_cyc !== 2) begin errors++; $display("FAIL t2_open_len w%0d got %0d exp 2", w, en_cyc); end
      checks++; if (if_a.lat_d !== wd[exp_id]) begin errors++; $display("FAIL t2_lat_d w%0d got %b exp %b", w, if_a.lat_d, wd[exp_id]); end
    end
    tick();
  endtask

  task automatic test_out_of_range();
    if_b.req = 4'b0100; if_b.addr = 12'(7) << 6; if_b.wdata = 4'b0100;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) if_b.req = 4'b0000;
      checks++; if (if_b.lat_en !== 5'b00000) begin errors++; $display("FAIL t3_en c%0d got %b exp 00000", c, if_b.lat_en); end
    end
    $display("write t3: ack=%b err=%b gnt=%0d", if_b.ack, if_b.err, if_b.gnt_id);
    checks++; if (if_b.ack !== 4'b0100) begin errors++; $display("FAIL t3_ack got %b exp 0100", if_b.ack); end
    checks++; if (if_b.err !== 1'b1) begin errors++; $display("FAIL t3_err got %b exp 1", if_b.err); end
    tick();
    checks++; if (if_b.err !== 1'b0) begin errors++; $display("FAIL t3_err_pulse got %b exp 0", if_b.err); end
    // Highest valid index (NLAT-1 = 4) must still be written.
    if_b.req = 4'b0100; if_b.addr = 12'(4) << 6;
    tick(); if_b.req = 4'b0000;
    tick();
    checks++; if (if_b.lat_en !== 5'b10000) begin errors++; $display("FAIL t3_top_en got %b exp 10000", if_b.lat_en); end
    tick(); tick(); tick();
    $display("write t3b: ack=%b err=%b gnt=%0d", if_b.ack, if_b.err, if_b.gnt_id);
    checks++; if (if_b.ack !== 4'b0100) begin errors++; $display("FAIL t3_top_ack got %b exp 0100", if_b.ack); end
    checks++; if (if_b.err !== 1'b0) begin errors++; $display("FAIL t3_top_err got %b exp 0", if_b.err); end
    tick();
  endtask

  task automatic test_req_drop();
    tick();
    if_a.req = 4'b0010; if_a.addr = 8'hC0 | 8'h0C; if_a.wdata = 4'b0010;
    tick();  // t+1
    if_a.req = 4'b0000; if_a.wdata = 4'b0000;
    tick();  // t+2
    checks++; if (if_a.lat_en !== 4'b1000) begin errors++; $display("FAIL t4_en got %b exp 1000", if_a.lat_en); end
    checks++; if (if_a.lat_d !== 1'b1) begin errors++; $display("FAIL t4_lat_d got %b exp 1", if_a.lat_d); end
    tick(); tick(); tick();  // t+5
    $display("write t4: ack=%b err=%b gnt=%0d lat_d=%b", if_a.ack, if_a.err, if_a.gnt_id, if_a.lat_d);
    checks++; if (if_a.ack !== 4'b0010) begin errors++; $display("FAIL t4_ack got %b exp 0010", if_a.ack); end
    checks++; if (if_a.gnt_id !== 2'd1) begin errors++; $display("FAIL t4_gnt got %0d exp 1", if_a.gnt_id); end
    tick();
    checks++; if (if_a.busy !== 1'b0) begin errors++; $display("FAIL t4_idle got %b exp 0", if_a.busy); end
  endtask

  task automatic test_reset_mid_open();
    if_a.req = 4'b1111; if_a.addr = {2'd3, 2'd2, 2'd1, 2'd0}; if_a.wdata = 4'b1010;
    tick(); tick();  // t+2: OPEN for requester 2
    checks++; if (if_a.lat_en !== 4'b0100) begin errors++; $display("FAIL t5_open got %b exp 0100", if_a.lat_en); end
    rst = 1'b1;
    #1;
    checks++; if (if_a.lat_en !== 4'b0000) begin errors++; $display("FAIL t5_rst_en got %b exp 0000", if_a.lat_en); end
    checks++; if (if_a.busy !== 1'b0) begin errors++; $display("FAIL t5_rst_busy got %b exp 0", if_a.busy); end
    checks++; if (if_a.ack !== 4'b0000) begin errors++; $display("FAIL t5_rst_ack got %b exp 0000", if_a.ack); end
    tick(); tick();
    rst = 1'b0;
    tick();  // grant after release
    if_a.req = 4'b0000;
    checks++; if (if_a.gnt_id !== 2'd0) begin errors++; $display("FAIL t5_gnt got %0d exp 0", if_a.gnt_id); end
    checks++; if (if_a.busy !== 1'b1) begin errors++; $display("FAIL t5_busy got %b exp 1", if_a.busy); end
    tick(); tick(); tick(); tick();
    $display("write t5: ack=%b gnt=%0d", if_a.ack, if_a.gnt_id);
    checks++; if (if_a.ack !== 4'b0001) begin errors++; $display("FAIL t5_ack got %b exp 0001", if_a.ack); end
    tick();
  endtask

  task automatic test_open_one();
    if_c.req = 4'b0001; if_c.addr = 8'h01; if_c.wdata = 4'b0001;
    tick(); if_c.req = 4'b0000;  // t+1
    checks++; if (if_c.lat_en !== 4'b0000) begin errors++; $display("FAIL t6_setup got %b exp 0000", if_c.lat_en); end
    tick();  // t+2
    checks++; if (if_c.lat_en !== 4'b0010) begin errors++; $display("FAIL t6_open got %b exp 0010", if_c.lat_en); end
    tick();  // t+3
    checks++; if (if_c.lat_en !== 4'b0000) begin errors++; $display("FAIL t6_hold got %b exp 0000", if_c.lat_en); end
    checks++; if (if_c.ack !== 4'b0000) begin errors++; $display("FAIL t6_early_ack got %b exp 0000", if_c.ack); end
    tick();  // t+4
    $display("write t6: ack=%b err=%b lat_d=%b", if_c.ack, if_c.err, if_c.lat_d);
    checks++; if (if_c.ack !== 4'b0001) begin errors++; $display("FAIL t6_ack got %b exp 0001", if_c.ack); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_out_of_range();
    test_req_drop();
    test_reset_mid_open();
    test_open_one();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
